// File: rtl/demux_rr_sched.sv
// Round-robin scheduler sharing a 1-bit, 1-to-8 demux path; grants one channel at a time for up to BURST beats.
// Request-to-grant latency is 1 cycle; routed beats appear 1 cycle after acceptance; in_ready is high only while a grant is held.
module demux_rr_sched #(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic [7:0] out,
  output logic [7:0] out_valid,
  output logic       busy
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [3:0] LAST = 4'(BURST - 1);

  state_t     state, state_nxt;
  logic [2:0] ptr;
  logic [2:0] winner;
  logic       found;
  logic [3:0] cnt;
  logic       acc;
  logic       burst_end;

  assign acc       = in_valid & in_ready;
  assign burst_end = (state == XFER) & ((acc & (cnt == LAST)) | ~req[sel]);

  // Circular search starting just after the last winner; i=8 wraps back to ptr itself.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!found && req[ptr + 3'(i)]) begin
        winner = ptr + 3'(i);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req)     state_nxt = XFER;
      XFER:    if (burst_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == XFER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 3'd7;
      sel       <= 3'd0;
      grant     <= 8'd0;
      out       <= 8'd0;
      out_valid <= 8'd0;
      busy      <= 1'b0;
      cnt       <= 4'd0;
    end else begin
      out       <= 8'd0;
      out_valid <= 8'd0;
      case (state)
        IDLE: begin
          if (|req) begin
            sel   <= winner;
            grant <= 8'b1 << winner;
            ptr   <= winner;
            busy  <= 1'b1;
            cnt   <= 4'd0;
          end
        end
        XFER: begin
          if (acc) begin
            out       <= 8'(in) << sel;
            out_valid <= grant;
            cnt       <= cnt + 4'd1;
          end
          // The beat accepted on the final cycle is still routed above; sel is kept.
          if (burst_end) begin
            grant <= 8'd0;
            busy  <= 1'b0;
            cnt   <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched: directed table, corner-case sequences and random traffic against a behavioural model.
module tb_demux_rr_sched;

  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       in;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] sel;
  logic [7:0] grant;
  logic [7:0] out;
  logic [7:0] out_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  demux_rr_sched #(.BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .in(in), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .grant(grant), .out(out),
    .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: owner is the channel holding the grant, -1 when idle.
  bit         known = 0;
  int         m_owner = -1;
  int         m_beats = 0;
  int         m_last = 7;
  logic [2:0] m_sel;
  logic [7:0] m_grant, m_out, m_ov;
  logic       m_busy;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic [7:0] q, input logic v, input logic d);
    m_out = 8'd0;
    m_ov  = 8'd0;
    if (r) begin
      known = 1; m_owner = -1; m_beats = 0; m_last = 7;
      m_sel = 3'd0; m_grant = 8'd0; m_busy = 1'b0;
    end else if (m_owner < 0) begin
      if (q != 8'd0) begin
        for (int k = 1; k <= 8; k++) begin
          if (m_owner < 0 && q[(m_last + k) % 8]) m_owner = (m_last + k) % 8;
        end
        m_last = m_owner; m_beats = 0;
        m_sel = 3'(m_owner); m_grant = 8'd1 << m_owner; m_busy = 1'b1;
      end
    end else begin
      if (v) begin
        m_beats++;
        m_ov  = 8'd1 << m_owner;
        m_out = d ? m_ov : 8'd0;
      end
      if ((v && m_beats == BURST) || !q[m_owner]) begin
        m_owner = -1; m_beats = 0; m_grant = 8'd0; m_busy = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, input logic [7:0] q, input logic v, input logic d);
    rst = r; req = q; in_valid = v; in = d;
    #1;
    if (known) check("in_ready", {7'd0, in_ready}, {7'd0, (m_owner >= 0)});
    @(posedge clk);
    model_update(r, q, v, d);
    #1;
    if (known) begin
      check("sel", {5'd0, sel}, {5'd0, m_sel});
      check("grant", grant, m_grant);
      check("out", out, m_out);
      check("out_valid", out_valid, m_ov);
      check("busy", {7'd0, busy}, {7'd0, m_busy});
    end
  endtask

  task automatic do_reset(input logic [7:0] q);
    step(1'b1, q, 1'b1, 1'b1);
    step(1'b1, q, 1'b1, 1'b1);
  endtask

  typedef struct {
    logic       r;
    logic [7:0] q;
    logic       v;
    logic       d;
    logic       rdy;
    logic [2:0] e_sel;
    logic [7:0] e_grant;
    logic [7:0] e_out;
    logic [7:0] e_ov;
    logic       e_busy;
  } vec_t;

  vec_t vecs[11];
  int   order[$];
  int   beats_per[$];
  int   exp_order[4];
  logic [7:0] prev_grant;
  logic [7:0] rq;
  int   npulse;

  initial begin
    // Reset with everything asserted, then single burst on channel 5 and its re-grant.
    vecs[0]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'bx, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 8'h01, 8'h00, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 3'd5, 8'h20, 8'h00, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 8'h20, 1'b1, 1'b1, 1'b1, 3'd5, 8'h20, 8'h20, 8'h20, 1'b1};
    vecs[6]  = '{1'b0, 8'h20, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20, 8'h00, 8'h20, 1'b1};
    vecs[7]  = '{1'b0, 8'h20, 1'b1, 1'b1, 1'b1, 3'd5, 8'h20, 8'h20, 8'h20, 1'b1};
    vecs[8]  = '{1'b0, 8'h20, 1'b1, 1'b1, 1'b1, 3'd5, 8'h00, 8'h20, 8'h20, 1'b0};
    vecs[9]  = '{1'b0, 8'h20, 1'b1, 1'b1, 1'b0, 3'd5, 8'h20, 8'h00, 8'h00, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 8'h00, 8'h00, 1'b0};

    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].r; req = vecs[i].q; in_valid = vecs[i].v; in = vecs[i].d;
      #1;
      if (i > 0) check("tbl_in_ready", {7'd0, in_ready}, {7'd0, vecs[i].rdy});
      step(vecs[i].r, vecs[i].q, vecs[i].v, vecs[i].d);
      check("tbl_sel", {5'd0, sel}, {5'd0, vecs[i].e_sel});
      check("tbl_grant", grant, vecs[i].e_grant);
      check("tbl_out", out, vecs[i].e_out);
      check("tbl_out_valid", out_valid, vecs[i].e_ov);
      check("tbl_busy", {7'd0, busy}, {7'd0, vecs[i].e_busy});
    end

    // Round robin between channels 0 and 7.
    do_reset(8'h00);
    exp_order = '{0, 7, 0, 7};
    prev_grant = 8'h00;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 8'h81, 1'b1, 1'($urandom));
      if (grant != 8'h00 && prev_grant == 8'h00) begin
        order.push_back(int'(sel));
        beats_per.push_back(0);
      end
      if (out_valid != 8'h00 && beats_per.size() > 0) beats_per[beats_per.size()-1]++;
      prev_grant = grant;
    end
    check("rr_grants", 8'(order.size() >= 4), 8'd1);
    if (order.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("rr_order", 8'(order[i]), 8'(exp_order[i]));
        if (i < 3) check("rr_beats", 8'(beats_per[i]), 8'(BURST));
      end
    end

    // Withdrawal on channel 3 during the third beat.
    do_reset(8'h00);
    step(1'b0, 8'h08, 1'b0, 1'b0);
    check("wd_grant", grant, 8'h08);
    step(1'b0, 8'h08, 1'b1, 1'b1);
    step(1'b0, 8'h08, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("wd_out", out, 8'h08);
    check("wd_out_valid", out_valid, 8'h08);
    check("wd_end_grant", grant, 8'h00);
    step(1'b0, 8'h08, 1'b0, 1'b0);
    check("wd_regrant", grant, 8'h08);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 8'h08, 1'b1, 1'b1);
      check("wd_full_busy", {7'd0, busy}, {7'd0, (i < 4)});
    end

    // Stall pattern on channel 2.
    do_reset(8'h00);
    step(1'b0, 8'h04, 1'b0, 1'b0);
    check("st_sel", {5'd0, sel}, 8'd2);
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h04, (i == 0 || i >= 3), 1'b1);
      if (out_valid == 8'h04) npulse++;
      if (i == 4) check("st_busy_mid", {7'd0, busy}, 8'd1);
    end
    check("st_pulses", 8'(npulse), 8'd4);
    check("st_busy_end", {7'd0, busy}, 8'd0);

    // Reset in the middle of a channel 6 burst.
    do_reset(8'h00);
    step(1'b0, 8'h40, 1'b0, 1'b0);
    check("rm_sel", {5'd0, sel}, 8'd6);
    step(1'b0, 8'h40, 1'b1, 1'b1);
    step(1'b0, 8'h40, 1'b1, 1'b1);
    step(1'b1, 8'h40, 1'b1, 1'b1);
    check("rm_out", out, 8'h00);
    check("rm_out_valid", out_valid, 8'h00);
    check("rm_grant", grant, 8'h00);
    check("rm_sel0", {5'd0, sel}, 8'd0);
    step(1'b0, 8'hFF, 1'b0, 1'b0);
    check("rm_next_grant", grant, 8'h01);

    // Random traffic against the model.
    do_reset(8'h00);
    rq = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
      step(($urandom_range(0, 99) == 0), rq, ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/demux_rr_sched.md
Name: demux_rr_sched

Overview:
Round-robin scheduler that shares one 1-bit, 1-to-8 demultiplexed data path among 8 destination channels. Each channel requests service. The block grants one channel at a time for a bounded burst, drives the 3-bit select, and routes accepted input beats to the granted output bit with a one-cycle registered valid pulse. It sits between a single serial source, which uses a valid/ready handshake, and eight per-channel consumers.

Parameters:
BURST, 4, maximum beats accepted per grant; legal range 1..16; the beat counter is 4 bits wide.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  synchronous reset, active-high
req  input  8  per-channel service request; bit i = channel i
in  input  1  serial data beat from the source
in_valid  input  1  source has a beat on `in`
in_ready  output  1  scheduler accepts the beat this cycle (combinational from state)
sel  output  3  index of the granted channel (registered)
grant  output  8  one-hot granted channel; all zero when idle (registered)
out  output  8  routed data; only bit `sel` can be nonzero (registered)
out_valid  output  8  one-hot, one-cycle pulse marking a routed beat (registered)
busy  output  1  high while a channel holds the grant (registered)

Behaviour:
- Reset, sampled at the clk edge with rst=1, gives on the next cycle:
  - state=IDLE, ptr=3'd7, sel=0, grant=0, out=0, out_valid=0, busy=0, beat counter=0.
  - rst overrides all other inputs.
- States: IDLE, XFER.
- Accept condition: acc = in_valid & in_ready.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - If req != 0, the next edge moves to XFER. The winner is the first set req bit searched circularly from (ptr+1) mod 8 upward.
  - On that edge: sel=winner, grant=1<<winner, ptr=winner, busy=1, counter=0.
  - Request-to-grant latency is 1 cycle.
  - If req == 0, stay in IDLE.
- XFER:
  - in_ready=1.
  - On acc, the next edge sets out[sel]=in, all other out bits=0, and out_valid=grant. The counter increments.
  - Without acc, the next edge sets out=0 and out_valid=0. The counter holds.
  - in_valid gaps stall the burst and do not end it.
- End of burst is the first XFER cycle where either condition holds:
  - acc with counter==BURST-1 (last beat), or
  - req[sel]==0 (request withdrawn).
- At end of burst:
  - The beat accepted in that cycle is still routed.
  - The next edge sets state=IDLE, grant=0, busy=0, counter=0. sel keeps its value.
  - Both end conditions in the same cycle give one end, not two.
  - There is always at least one IDLE cycle between grants.
- Fairness:
  - ptr always holds the last winner, so the just-served channel has lowest priority.
  - A sole requester is re-granted after the 1-cycle IDLE gap.
- req bits other than req[sel] changing during XFER have no effect until the next IDLE.
- BURST=1: every grant carries exactly one beat, then IDLE.
- A reset during XFER aborts the burst. A beat presented in the reset cycle is not routed, and ptr returns to 7.
- Outputs never contain X. out and out_valid are zero on every cycle with no routed beat.

Test Plan:
1. Reset: hold rst=1 two cycles with req=8'hFF and in_valid=1 -> sel=0, grant=0, out=0, out_valid=0, busy=0, in_ready=0; one cycle after rst drops, grant=8'h01 and sel=0.
2. Single burst: BURST=4, req=8'b0010_0000, in_valid=1, in=1,0,1,1 -> grant=8'h20, sel=5; out_valid=8'h20 on 4 consecutive cycles with out=8'h20, 8'h00, 8'h20, 8'h20; then busy=0 for one cycle; then channel 5 is re-granted.
3. Round robin: req=8'b1000_0001 held, in_valid=1 -> grant order ch0, ch7, ch0, ch7, each 4 beats with a 1-cycle IDLE gap between grants.
4. Withdrawal: grant ch3, accept 2 beats, deassert req[3] while the 3rd beat is valid -> 3rd beat routed to out[3], then IDLE; the counter restarts at 0 on the next grant.
5. Stall: in_valid pattern 1,0,0,1,1,1 during a ch2 grant -> exactly 4 out_valid pulses; the grant ends only after the 4th accepted beat.
6. Reset mid-burst: assert rst after 2 beats on ch6 -> next cycle all outputs are zero; with req=8'hFF the next grant is ch0, not ch7.
